int_ctrl: RTL

Interrupt controller between the external `int` pin and the processor fetch stage. It synchronizes the asynchronous request and detects edges (or samples level). It holds the request pending until the core accepts it and blocks nesting until RTI retires. A second request that arrives during the ISR is queued one-deep; further overflow is counted. The fetch stage consumes `int_req` to push PC and load PC from M[1].

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/sync_ff.sv | 34 +++
 rtl/int_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end: interrupt controller state
// encodings, the drop-counter width and a saturating increment helper.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DROP_W = 8;

   typedef enum logic [1:0] {
      INT_IDLE = 2'd0,
      INT_PEND = 2'd1,
      INT_ISR  = 2'd2
   } int_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] i_val);
      return (&i_val) ? i_val : i_val + {{(DROP_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, all stages cleared to 0
//   i_d  - asynchronous input
//   o_q  - synchronized output, STAGES clock edges behind i_d
// STAGES must be at least 2 for metastability protection.
// -----------------------------------------------------------------------------
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, giving a true shift chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// Interrupt controller between the external interrupt pin and instruction
// fetch. Synchronizes the pin, detects rising edges (or samples the level),
// holds the request pending until the core takes it, blocks nesting until
// RTI retires, queues one further request and counts anything beyond that.
// Ports:
//   clk       - core clock
//   rst       - asynchronous active-high reset
//   int_in    - external interrupt, asynchronous to clk
//   int_en    - global enable, masks int_req only
//   stall     - fetch stalled, masks int_req
//   flush     - branch/flush in flight, masks int_req
//   int_ack   - pulse: core committed interrupt entry
//   rti_done  - pulse: RTI retired
//   int_req   - request to fetch stage
//   in_isr    - ISR active
//   queued    - one request waiting behind the current ISR
//   drop_cnt  - saturating count of merged/lost requests
// -----------------------------------------------------------------------------
module int_ctrl
   import cpu_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              int_in,
   input  logic              int_en,
   input  logic              stall,
   input  logic              flush,
   input  logic              int_ack,
   input  logic              rti_done,
   output logic              int_req,
   output logic              in_isr,
   output logic              queued,
   output logic [DROP_W-1:0] drop_cnt
);

   logic              w_s;
   logic              w_evt;
   logic              w_accept;
   logic              r_prev;
   int_state_e        r_state;
   logic              r_in_isr;
   logic              r_queued;
   logic [DROP_W-1:0] r_drop;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (int_in),
      .o_q (w_s)
   );

   // prev resets to 0, so a pin already high at reset release is one edge.
   assign w_evt = (EDGE_MODE != 0) ? (w_s & ~r_prev) : w_s;

   // An ack only counts when the core could actually have seen the request.
   assign w_accept = int_ack & int_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= INT_IDLE;
         r_prev   <= 1'b0;
         r_in_isr <= 1'b0;
         r_queued <= 1'b0;
         r_drop   <= '0;
      end else begin
         r_prev <= w_s;
         case (r_state)
            INT_IDLE: begin
               if (w_evt) begin
                  r_state <= INT_PEND;
               end
            end

            INT_PEND: begin
               if (w_accept) begin
                  r_state  <= INT_ISR;
                  r_in_isr <= 1'b1;
                  // A new request landing on the entry cycle belongs to the next ISR.
                  if (w_evt) begin
                     r_queued <= 1'b1;
                  end
               end else if (w_evt && (EDGE_MODE != 0)) begin
                  // Already pending: the new edge merges into the current one.
                  r_drop <= sat_inc(r_drop);
               end
            end

            INT_ISR: begin
               if (rti_done) begin
                  r_in_isr <= 1'b0;
                  r_queued <= 1'b0;
                  r_state  <= (r_queued || w_evt) ? INT_PEND : INT_IDLE;
               end else if (EDGE_MODE == 0) begin
                  r_queued <= w_s;
               end else if (w_evt) begin
                  if (r_queued) begin
                     r_drop <= sat_inc(r_drop);
                  end else begin
                     r_queued <= 1'b1;
                  end
               end
            end

            default: begin
               r_state  <= INT_IDLE;
               r_in_isr <= 1'b0;
               r_queued <= 1'b0;
            end
         endcase
      end
   end

   // Masks act in the same cycle and never disturb the pending state.
   assign int_req  = (r_state == INT_PEND) & int_en & ~stall & ~flush;
   assign in_isr   = r_in_isr;
   assign queued   = r_queued;
   assign drop_cnt = r_drop;

endmodule
